// File: rtl/hbm_phy_responder.sv
// PHY-side responder: accepts one-beat read/write commands, runs fixed-length bursts
// against an internal word array, returns read data after RD_LAT idle cycles.
module hbm_phy_responder #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phy_cmd_valid,
  input  logic              phy_cmd,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic              phy_wr_valid,
  input  logic [DATA_W-1:0] phy_wr_data,
  output logic              phy_ready,
  output logic              phy_rd_valid,
  output logic [DATA_W-1:0] phy_rd_data,
  output logic              phy_error,
  output logic              err_sticky
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int LAT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  typedef enum logic [2:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST, ERR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                ready_q, ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                error_q, error_d;
  logic                sticky_q, sticky_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [ADDR_W:0]     end_addr;
  logic                out_of_range;

  // One extra bit keeps addresses near the top of the space from wrapping into range.
  assign end_addr     = {1'b0, phy_addr} + (ADDR_W+1)'(BURST_LEN);
  assign out_of_range = end_addr > (ADDR_W+1)'(DEPTH);
  assign mem_idx      = base_q + IDX_W'(beat_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (phy_cmd_valid && ready_q) begin
          if (out_of_range) begin
            state_d = ERR;
          end else begin
            base_d = phy_addr[IDX_W-1:0];
            beat_d = '0;
            lat_d  = '0;
            if (phy_cmd)          state_d = WR_BURST;
            else if (RD_LAT == 0) state_d = RD_BURST;
            else                  state_d = RD_WAIT;
          end
        end
      end
      WR_BURST: begin
        if (phy_wr_valid) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(LAT_LAST)) state_d = RD_BURST;
        else                           lat_d   = lat_q + 1'b1;
      end
      RD_BURST: begin
        // Beat count reaching BURST_LEN marks the cycle after the last beat.
        if (beat_q == BEAT_W'(BURST_LEN)) begin
          state_d = IDLE;
        end else begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[mem_idx];
          beat_d     = beat_q + 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    error_d  = (state_d == ERR);
    sticky_d = sticky_q | error_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      error_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      error_q    <= error_d;
      sticky_q   <= sticky_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= phy_wr_data;
  end

  assign phy_ready    = ready_q;
  assign phy_rd_valid = rd_valid_q;
  assign phy_rd_data  = rd_data_q;
  assign phy_error    = error_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_hbm_phy_responder.sv
// Scoreboard bench for hbm_phy_responder: one instance with RD_LAT=2, one with RD_LAT=0.
module tb_hbm_phy_responder;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int BL     = 4;
  localparam int LAT0   = 2;
  localparam int LAT1   = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic              cmd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ready0, rd_valid0, error0, sticky0;
  logic              ready1, rd_valid1, error1, sticky1;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model0 [DEPTH];
  logic [DATA_W-1:0] model1 [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  hbm_phy_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST_LEN(BL), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .reset(reset), .phy_cmd_valid(cmd_valid0), .phy_cmd(cmd), .phy_addr(addr),
    .phy_wr_valid(wr_valid), .phy_wr_data(wr_data), .phy_ready(ready0), .phy_rd_valid(rd_valid0),
    .phy_rd_data(rd_data0), .phy_error(error0), .err_sticky(sticky0));

  hbm_phy_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST_LEN(BL), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset), .phy_cmd_valid(cmd_valid1), .phy_cmd(cmd), .phy_addr(addr),
    .phy_wr_valid(wr_valid), .phy_wr_data(wr_data), .phy_ready(ready1), .phy_rd_valid(rd_valid1),
    .phy_rd_data(rd_data1), .phy_error(error1), .err_sticky(sticky1));

  function automatic logic get_ready(input int sel);  return (sel != 0) ? ready1 : ready0;       endfunction
  function automatic logic get_rv(input int sel);     return (sel != 0) ? rd_valid1 : rd_valid0; endfunction
  function automatic logic get_err(input int sel);    return (sel != 0) ? error1 : error0;       endfunction
  function automatic logic get_sticky(input int sel); return (sel != 0) ? sticky1 : sticky0;     endfunction
  function automatic logic [DATA_W-1:0] get_rd(input int sel); return (sel != 0) ? rd_data1 : rd_data0; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cv(input int sel, input logic v);
    if (sel != 0) cmd_valid1 = v;
    else          cmd_valid0 = v;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // pat is consumed MSB-first over plen cycles; a 1 presents the next data beat.
  task automatic do_write(input int sel, input logic [ADDR_W-1:0] a, input logic [15:0] pat,
                          input int plen, input logic [DATA_W-1:0] base_data);
    int written = 0;
    $display("txn dut%0d write addr=%0d", sel, a);
    checks++;
    if (get_ready(sel) !== 1'b1) begin errors++; $display("FAIL wr_ready_pre got=%b exp=1", get_ready(sel)); end
    cmd = 1'b1; addr = a; set_cv(sel, 1'b1);
    wr_valid = 1'b1; wr_data = '1;
    tick();
    set_cv(sel, 1'b0);
    for (int i = 0; i < plen; i++) begin
      checks++;
      if (get_ready(sel) !== 1'b0) begin errors++; $display("FAIL wr_ready_busy beat=%0d got=%b exp=0", written, get_ready(sel)); end
      wr_valid = pat[plen-1-i];
      if (wr_valid) begin
        wr_data = base_data + DATA_W'(written);
        if (sel != 0) model1[a + written] = wr_data;
        else          model0[a + written] = wr_data;
        written++;
      end else begin
        wr_data = ~base_data;
      end
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (get_ready(sel) !== 1'b1) begin errors++; $display("FAIL wr_ready_after got=%b exp=1", get_ready(sel)); end
  endtask

  task automatic do_read(input int sel, input logic [ADDR_W-1:0] a, input bit hold);
    int n = 0;
    int lat = (sel != 0) ? LAT1 : LAT0;
    logic [DATA_W-1:0] exp_d;
    $display("txn dut%0d read addr=%0d hold=%0d", sel, a, hold);
    checks++;
    if (get_ready(sel) !== 1'b1) begin errors++; $display("FAIL rd_ready_pre got=%b exp=1", get_ready(sel)); end
    for (int b = 0; b < BL; b++) exp_q.push_back((sel != 0) ? model1[a + b] : model0[a + b]);
    cmd = 1'b0; addr = a; set_cv(sel, 1'b1);
    tick();
    if (hold) begin cmd = 1'b1; addr = '0; end
    else set_cv(sel, 1'b0);
    while (get_rv(sel) !== 1'b1 && n < 20) begin
      checks++;
      if (get_ready(sel) !== 1'b0 || get_rd(sel) !== '0) begin
        errors++; $display("FAIL rd_wait_idle ready=%b data=%0h exp ready=0 data=0", get_ready(sel), get_rd(sel));
      end
      tick();
      n++;
    end
    checks++;
    if (n != lat + 1) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", n, lat + 1); end
    for (int b = 0; b < BL; b++) begin
      exp_d = exp_q.pop_front();
      checks++;
      if (get_rv(sel) !== 1'b1 || get_rd(sel) !== exp_d || get_ready(sel) !== 1'b0) begin
        errors++;
        $display("FAIL rd_beat%0d valid=%b ready=%b data=%0h exp valid=1 ready=0 data=%0h",
                 b, get_rv(sel), get_ready(sel), get_rd(sel), exp_d);
      end
      if (hold && b == BL - 1) set_cv(sel, 1'b0);
      tick();
    end
    checks++;
    if (get_rv(sel) !== 1'b0 || get_rd(sel) !== '0 || get_ready(sel) !== 1'b1) begin
      errors++; $display("FAIL rd_end valid=%b ready=%b data=%0h exp valid=0 ready=1 data=0",
                         get_rv(sel), get_ready(sel), get_rd(sel));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (get_rv(sel) !== 1'b0) begin errors++; $display("FAIL rd_extra_beat got=%b exp=0", get_rv(sel)); end
    end
  endtask

  task automatic do_error(input int sel, input logic [ADDR_W-1:0] a, input logic wr);
    $display("txn dut%0d bad cmd=%0d addr=%0h", sel, wr, a);
    cmd = wr; addr = a; set_cv(sel, 1'b1);
    wr_valid = wr; wr_data = '1;
    tick();
    set_cv(sel, 1'b0);
    checks++;
    if (get_err(sel) !== 1'b1 || get_ready(sel) !== 1'b0 || get_sticky(sel) !== 1'b1 || get_rv(sel) !== 1'b0) begin
      errors++; $display("FAIL err_pulse err=%b ready=%b sticky=%b rv=%b exp 1 0 1 0",
                         get_err(sel), get_ready(sel), get_sticky(sel), get_rv(sel));
    end
    tick();
    checks++;
    if (get_err(sel) !== 1'b0 || get_ready(sel) !== 1'b1 || get_sticky(sel) !== 1'b1) begin
      errors++; $display("FAIL err_clear err=%b ready=%b sticky=%b exp 0 1 1",
                         get_err(sel), get_ready(sel), get_sticky(sel));
    end
    tick();
    wr_valid = 1'b0;
    checks++;
    if (get_err(sel) !== 1'b0 || get_sticky(sel) !== 1'b1) begin
      errors++; $display("FAIL err_sticky_hold err=%b sticky=%b exp 0 1", get_err(sel), get_sticky(sel));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready0 !== 1'b1 || rd_valid0 !== 1'b0 || rd_data0 !== '0 || error0 !== 1'b0 || sticky0 !== 1'b0) begin
      errors++; $display("FAIL reset_hold ready=%b rv=%b err=%b sticky=%b exp 1 0 0 0", ready0, rd_valid0, error0, sticky0);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (ready0 !== 1'b1 || rd_valid0 !== 1'b0 || error0 !== 1'b0 || sticky0 !== 1'b0 || ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_release ready=%b rv=%b err=%b sticky=%b ready1=%b exp 1 0 0 0 1",
                         ready0, rd_valid0, error0, sticky0, ready1);
    end
  endtask

  task automatic test_write_read();
    do_write(0, 4, 16'hF, 4, 512'hA0);
    do_read(0, 4, 1'b0);
  endtask

  task automatic test_gaps();
    do_write(0, 0, 16'b1001101, 7, rand_word());
    do_read(0, 0, 1'b0);
  endtask

  task automatic test_range_error();
    do_write(0, 12, 16'hF, 4, rand_word());
    do_error(0, 13, 1'b1);
    do_read(0, 12, 1'b0);
    do_error(0, 13, 1'b0);
  endtask

  task automatic test_wrap_error();
    do_error(0, 32'hFFFF_FFFE, 1'b0);
    do_read(0, 12, 1'b0);
  endtask

  task automatic test_cmd_held();
    do_read(0, 4, 1'b1);
  endtask

  task automatic test_rd_lat0();
    do_write(1, 8, 16'hF, 4, rand_word());
    do_read(1, 8, 1'b0);
    do_read(1, 8, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    $display("txn dut0 read addr=4 with reset mid-burst");
    cmd = 1'b0; addr = 4; cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    while (rd_valid0 !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    checks++;
    if (rd_valid0 !== 1'b1) begin errors++; $display("FAIL mid_read_active got=%b exp=1", rd_valid0); end
    reset = 1'b1;
    #1;
    checks++;
    if (rd_valid0 !== 1'b0 || ready0 !== 1'b1 || sticky0 !== 1'b0) begin
      errors++; $display("FAIL rst_async rv=%b ready=%b sticky=%b exp 0 1 0", rd_valid0, ready0, sticky0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rd_valid0 !== 1'b0 || rd_data0 !== '0 || ready0 !== 1'b1) begin
        errors++; $display("FAIL rst_no_beats cyc=%0d rv=%b ready=%b exp 0 1", i, rd_valid0, ready0);
      end
    end
    do_read(0, 4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_gaps();
    test_range_error();
    test_wrap_error();
    test_cmd_held();
    test_rd_lat0();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
